// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// forward-select codes and the operand-forwarding decision helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // The younger result (EX/MEM) wins over the older one (MEM/WB); x0 is never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic [4:0] mem_rd,
    input logic       mem_reg_write,
    input logic [4:0] wb_rd,
    input logic       wb_reg_write
  );
    logic [1:0] sel;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Combinational operand-forwarding selector for one ALU source operand.
module forward_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] forward
);

  assign forward = fwd_select(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout halt, branch flush,
// load-use bubble insertion, operand forwarding and stall/flush perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic        mem_branch_taken,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        halted,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              load_use;
  logic              stall_evt;
  logic              flush_evt;
  logic [1:0]        fwd_a_raw;
  logic [1:0]        fwd_b_raw;
  logic              unused_inputs;

  // A load's destination register is always written, so ex_reg_write adds nothing here.
  assign unused_inputs = ex_reg_write;

  assign freeze   = dmem_req && !dmem_ready && ((state == ST_RUN) || (state == ST_MEM_WAIT));
  assign load_use = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  forward_unit u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .forward       (fwd_a_raw)
  );

  forward_unit u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .forward       (fwd_b_raw)
  );

  assign forward_a = reset ? FWD_NONE : fwd_a_raw;
  assign forward_b = reset ? FWD_NONE : fwd_b_raw;

  // Same-cycle enable/flush priority: HALT > freeze > branch flush > load-use > normal.
  // A branch seen during a freeze stays on the frozen EX/MEM inputs, so its flush
  // lands naturally in the first cycle the memory reports ready.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    if (reset) begin
      stall_evt = 1'b0;
    end else begin
      case (state)
        ST_HALT: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end
        ST_RUN, ST_MEM_WAIT: begin
          if (freeze) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            stall_evt = 1'b1;
          end else if (mem_branch_taken) begin
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            flush_evt = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_evt  = 1'b1;
          end else begin
            flush_evt = 1'b0;
          end
        end
        default: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end
      endcase
    end
  end

  // Memory-wait FSM, timeout counter, halt flag and saturating perf counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      halted      <= 1'b0;
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (freeze) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            state <= ST_RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state  <= ST_HALT;
          halted <= 1'b1;
        end
      endcase
      if (stall_evt && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (flush_evt && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: a vector table for the
// single-cycle hazard/forwarding decisions plus hand-written multi-cycle sequences.
module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic        ex_mem_read, ex_reg_write, mem_reg_write, mem_branch_taken;
  logic        wb_reg_write, dmem_req, dmem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  forward_a, forward_b;
  logic        halted;
  logic [15:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hazard_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_branch_taken(mem_branch_taken),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .forward_a(forward_a), .forward_b(forward_b),
    .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
  );

  wire [4:0] en_bus = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  wire [2:0] fl_bus = {ifid_flush, idex_flush, exmem_flush};

  typedef struct {
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_read;
    logic [4:0] ex_rs1, ex_rs2, mem_rd;
    logic       mem_reg_write, mem_branch_taken;
    logic [4:0] wb_rd;
    logic       wb_reg_write;
    logic [4:0] exp_en;
    logic [2:0] exp_fl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(
    input logic [4:0] r1, r2, erd, input logic mr,
    input logic [4:0] ers1, ers2, mrd, input logic mw, br,
    input logic [4:0] wrd, input logic ww,
    input logic [4:0] een, input logic [2:0] efl, input logic [1:0] efa, efb);
    vec_t v;
    v.id_rs1 = r1; v.id_rs2 = r2; v.ex_rd = erd; v.ex_mem_read = mr;
    v.ex_rs1 = ers1; v.ex_rs2 = ers2; v.mem_rd = mrd; v.mem_reg_write = mw;
    v.mem_branch_taken = br; v.wb_rd = wrd; v.wb_reg_write = ww;
    v.exp_en = een; v.exp_fl = efl; v.exp_fa = efa; v.exp_fb = efb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; mem_rd = 5'd0; mem_reg_write = 1'b0;
    mem_branch_taken = 1'b0; wb_rd = 5'd0; wb_reg_write = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'b00, 2'b00);
    vecs[1]  = mk(5'd0, 5'd5, 5'd5, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00111, 3'b010, 2'b00, 2'b00);
    vecs[2]  = mk(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'b00, 2'b00);
    vecs[3]  = mk(5'd7, 5'd2, 5'd7, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00111, 3'b010, 2'b00, 2'b00);
    vecs[4]  = mk(5'd7, 5'd2, 5'd7, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'b00, 2'b00);
    vecs[5]  = mk(5'd0, 5'd5, 5'd5, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'b11111, 3'b111, 2'b00, 2'b00);
    vecs[6]  = mk(5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 5'b11111, 3'b000, 2'b10, 2'b00);
    vecs[7]  = mk(5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 5'd0, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 5'b11111, 3'b000, 2'b01, 2'b00);
    vecs[8]  = mk(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b00);
    vecs[9]  = mk(5'd0, 5'd0, 5'd0, 1'b0, 5'd4, 5'd9, 5'd4, 1'b1, 1'b0, 5'd9, 1'b1, 5'b11111, 3'b000, 2'b10, 2'b01);
    vecs[10] = mk(5'd0, 5'd0, 5'd0, 1'b0, 5'd6, 5'd4, 5'd4, 1'b1, 1'b0, 5'd4, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b10);
    vecs[11] = mk(5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 5'd3, 1'b0, 5'b11111, 3'b000, 2'b00, 2'b00);

    // Reset dominates: hazards, freeze and forwarding all present.
    clr();
    reset = 1'b1;
    id_rs2 = 5'd5; ex_rd = 5'd5; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    dmem_req = 1'b1; mem_branch_taken = 1'b1;
    ex_rs1 = 5'd3; mem_rd = 5'd3; mem_reg_write = 1'b1;
    #2;
    chk("rst_en", en_bus, 5'b11111);
    chk("rst_fl", fl_bus, 3'b000);
    chk("rst_fa", forward_a, 2'b00);
    tick();
    tick();
    chk("rst_halted", halted, 1'b0);
    chk("rst_stall", stall_count, 16'd0);
    chk("rst_flush", flush_count, 16'd0);
    do_reset();

    // Single-cycle decision table.
    for (int i = 0; i < 12; i++) begin
      clr();
      id_rs1 = vecs[i].id_rs1; id_rs2 = vecs[i].id_rs2; ex_rd = vecs[i].ex_rd;
      ex_mem_read = vecs[i].ex_mem_read; ex_reg_write = vecs[i].ex_mem_read;
      ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2;
      mem_rd = vecs[i].mem_rd; mem_reg_write = vecs[i].mem_reg_write;
      mem_branch_taken = vecs[i].mem_branch_taken;
      wb_rd = vecs[i].wb_rd; wb_reg_write = vecs[i].wb_reg_write;
      #1;
      chk($sformatf("vec%0d_en", i), en_bus, vecs[i].exp_en);
      chk($sformatf("vec%0d_fl", i), fl_bus, vecs[i].exp_fl);
      chk($sformatf("vec%0d_fa", i), forward_a, vecs[i].exp_fa);
      chk($sformatf("vec%0d_fb", i), forward_b, vecs[i].exp_fb);
      tick();
    end

    // Load-use: one bubble, then the bubble reaches EX; x0 destination never stalls.
    do_reset();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
    #1;
    chk("lu_en", en_bus, 5'b00111);
    tick();
    chk("lu_stall1", stall_count, 16'd1);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    #1;
    chk("lu_after_en", en_bus, 5'b11111);
    tick();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    chk("lu_x0_en", en_bus, 5'b11111);
    tick();
    chk("lu_stall_hold", stall_count, 16'd1);

    // Branch flush overrides load-use.
    do_reset();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; mem_branch_taken = 1'b1;
    #1;
    chk("br_fl", fl_bus, 3'b111);
    chk("br_en", en_bus, 5'b11111);
    tick();
    chk("br_flush_cnt", flush_count, 16'd1);
    chk("br_stall_cnt", stall_count, 16'd0);

    // Memory wait of three cycles, then ready.
    do_reset();
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_en%0d", i), en_bus, 5'b00000);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("mw_ready_en", en_bus, 5'b11111);
    tick();
    clr();
    #1;
    chk("mw_stall_cnt", stall_count, 16'd3);
    chk("mw_halted", halted, 1'b0);
    chk("mw_run_en", en_bus, 5'b11111);

    // Branch during freeze is deferred to the ready cycle; forwarding stays live.
    do_reset();
    dmem_req = 1'b1; mem_branch_taken = 1'b1;
    ex_rs1 = 5'd3; mem_rd = 5'd3; mem_reg_write = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("fb_fl%0d", i), fl_bus, 3'b000);
      chk($sformatf("fb_en%0d", i), en_bus, 5'b00000);
      chk($sformatf("fb_fa%0d", i), forward_a, 2'b10);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("fb_ready_fl", fl_bus, 3'b111);
    chk("fb_ready_en", en_bus, 5'b11111);
    tick();
    chk("fb_flush_cnt", flush_count, 16'd1);
    chk("fb_stall_cnt", stall_count, 16'd2);

    // Timeout: 17 freeze cycles, then HALT until reset.
    do_reset();
    dmem_req = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      if (en_bus != 5'b00000 || halted != 1'b0)
        chk($sformatf("to_freeze%0d", i), {en_bus, halted}, {5'b00000, 1'b0});
      tick();
    end
    chk("to_freeze_cycles", stall_count, 16'd17);
    chk("to_halted", halted, 1'b1);
    dmem_ready = 1'b1; mem_branch_taken = 1'b1;
    #1;
    chk("to_halt_en", en_bus, 5'b00000);
    chk("to_halt_fl", fl_bus, 3'b000);
    tick();
    chk("to_halt_stay", halted, 1'b1);
    chk("to_halt_stall", stall_count, 16'd17);
    chk("to_halt_flush", flush_count, 16'd0);
    reset = 1'b1;
    #1;
    chk("to_rst_en", en_bus, 5'b11111);
    tick();
    reset = 1'b0;
    clr();
    chk("to_rst_halted", halted, 1'b0);
    chk("to_rst_stall", stall_count, 16'd0);
    chk("to_rst_flush", flush_count, 16'd0);
    #1;
    chk("to_rst_run_en", en_bus, 5'b11111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
